// File: rtl/simmem_pkg.sv
// Shared definitions for the simulated-memory response path: bank capacities,
// internal-identifier types and the release-arbiter state encoding.
package simmem_pkg;

    localparam int unsigned WRspBankCapa  = 4;
    localparam int unsigned RDataBankCapa = 4;

    typedef logic [$clog2(WRspBankCapa)-1:0]  write_iid_t;
    typedef logic [$clog2(RDataBankCapa)-1:0] read_iid_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker: grants the first request at or above the
// pointer, wrapping to the lowest request when none lies at or above it.
module simmem_rr_picker #(
    parameter int unsigned Width    = 4,
    parameter int unsigned IdxWidth = $clog2(Width)
) (
    input  logic [Width-1:0]    i_req,
    input  logic [IdxWidth-1:0] i_ptr,
    output logic [Width-1:0]    o_gnt_onehot,
    output logic [IdxWidth-1:0] o_gnt_idx,
    output logic                o_gnt_any
);

    logic                w_hi_found;
    logic [IdxWidth-1:0] w_hi_idx;
    logic [IdxWidth-1:0] w_lo_idx;

    // Scanning downward lets the lowest matching index win in both searches.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = IdxWidth'(i);
                if (IdxWidth'(i) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IdxWidth'(i);
                end
            end
        end
    end

    assign o_gnt_any = |i_req;
    assign o_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        o_gnt_onehot = '0;
        if (o_gnt_any) begin
            o_gnt_onehot[o_gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/simmem_release_arbiter.sv
// Round-robin release arbiter between the delay calculator and a response bank.
// Optional stall counter output enabled by defining SIMMEM_RELEASE_ARB_STATS_EN.
module simmem_release_arbiter
    import simmem_pkg::*;
#(
    parameter int unsigned Capacity = WRspBankCapa,
    parameter int unsigned IidWidth = $clog2(Capacity)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Capacity-1:0] release_en_mhot_i,
    output logic                rsp_valid_o,
    output logic [IidWidth-1:0] rsp_iid_o,
    input  logic                rsp_ready_i,
    output logic [Capacity-1:0] released_iid_onehot_o
`ifdef SIMMEM_RELEASE_ARB_STATS_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic [IidWidth-1:0] r_iid;
    logic [IidWidth-1:0] w_iid_next;
    logic [IidWidth-1:0] r_rr_ptr;
    logic [IidWidth-1:0] w_ptr_after_rel;
    logic [Capacity-1:0] r_held_onehot;
    logic [Capacity-1:0] w_held_onehot_next;
    logic [Capacity-1:0] r_last_rel_mask;
    logic [Capacity-1:0] w_held_mask;
    logic [Capacity-1:0] w_eligible;
    logic [Capacity-1:0] w_gnt_onehot;
    logic [IidWidth-1:0] w_gnt_idx;
    logic                w_gnt_any;
    logic                w_handshake;

    assign w_handshake = (r_state == FULL) && rsp_ready_i;
    assign w_held_mask = (r_state == FULL) ? r_held_onehot : '0;

    // The held iid is masked too, so a handshake cycle never re-grants what it releases.
    assign w_eligible  = release_en_mhot_i & ~w_held_mask & ~r_last_rel_mask;

    assign w_ptr_after_rel = (r_iid == IidWidth'(Capacity - 1)) ? '0 : r_iid + 1'b1;

    simmem_rr_picker #(
        .Width    (Capacity),
        .IdxWidth (IidWidth)
    ) u_picker (
        .i_req        (w_eligible),
        .i_ptr        (r_rr_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx),
        .o_gnt_any    (w_gnt_any)
    );

    always_comb begin
        w_state_next       = r_state;
        w_iid_next         = r_iid;
        w_held_onehot_next = r_held_onehot;
        case (r_state)
            EMPTY: begin
                if (w_gnt_any) begin
                    w_state_next       = FULL;
                    w_iid_next         = w_gnt_idx;
                    w_held_onehot_next = w_gnt_onehot;
                end
            end
            FULL: begin
                if (w_handshake) begin
                    if (w_gnt_any) begin
                        w_iid_next         = w_gnt_idx;
                        w_held_onehot_next = w_gnt_onehot;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= EMPTY;
            r_iid           <= '0;
            r_held_onehot   <= '0;
            r_rr_ptr        <= '0;
            r_last_rel_mask <= '0;
        end else begin
            r_state         <= w_state_next;
            r_iid           <= w_iid_next;
            r_held_onehot   <= w_held_onehot_next;
            r_last_rel_mask <= w_handshake ? r_held_onehot : '0;
            if (w_handshake) begin
                r_rr_ptr <= w_ptr_after_rel;
            end
        end
    end

    assign rsp_valid_o           = (r_state == FULL);
    assign rsp_iid_o             = r_iid;
    assign released_iid_onehot_o = w_handshake ? r_held_onehot : '0;

`ifdef SIMMEM_RELEASE_ARB_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (rsp_valid_o && !rsp_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
